// File: rtl/alu_wb_stage.sv
// ALU writeback stage: buffers lane results in a small FIFO and retires them to the
// register file in order, turning illegal-op results into a one-cycle exception pulse.
module alu_wb_stage #(
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      done,
   output logic                      wb_ready,
   input  logic [31:0]               alu_out,
   input  logic [3:0]                write_en,
   input  logic [3:0]                Z,
   input  logic [3:0]                N,
   input  logic [3:0]                C,
   input  logic [3:0]                V,
   input  logic                      illegal_opcode,
   input  logic [4:0]                warp_id_i,
   input  logic [3:0]                dst_reg,
   input  logic                      flush,
   output logic                      rf_valid,
   input  logic                      rf_ready,
   output logic [8:0]                rf_addr,
   output logic [31:0]               rf_wdata,
   output logic [3:0]                rf_we,
   output logic [15:0]               rf_flags,
   output logic                      exc_valid,
   output logic [4:0]                exc_warp,
   output logic [$clog2(DEPTH):0]    count,
   output logic [15:0]               retired
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 62;

   // Entry layout: {alu_out, write_en, {V,C,N,Z}, illegal, warp, dst}
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [15:0]   retired_q, retired_d;
   logic          exc_valid_q, exc_valid_d;
   logic [4:0]    exc_warp_q, exc_warp_d;

   logic [EW-1:0] entry_s;
   logic [EW-1:0] head_s;
   logic          not_empty_s;
   logic          wb_ready_s;
   logic          head_write_s;
   logic          head_exc_s;
   logic          push_s;
   logic          pop_s;

   // Head classification and handshake decode, all from registered state
   always_comb begin
      entry_s      = {alu_out, write_en, V, C, N, Z, illegal_opcode, warp_id_i, dst_reg};
      head_s       = mem_q[rd_ptr_q];
      not_empty_s  = (count_q != {CW{1'b0}});
      wb_ready_s   = (count_q < CW'(DEPTH));
      head_write_s = not_empty_s && !head_s[9] && (head_s[29:26] != 4'b0000);
      head_exc_s   = not_empty_s && head_s[9];
      push_s       = !flush && done && wb_ready_s;
      if (head_write_s) begin
         pop_s = !flush && rf_ready;
      end else begin
         pop_s = !flush && not_empty_s;
      end
   end

   // Pointer, occupancy, retire-counter and exception next-state
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      retired_d   = retired_q;
      exc_valid_d = pop_s && head_exc_s;
      exc_warp_d  = exc_warp_q;
      if (flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
      if (pop_s && head_write_s && (retired_q != 16'hFFFF)) begin
         retired_d = retired_q + 16'h0001;
      end else begin
         retired_d = retired_q;
      end
      if (exc_valid_d) begin
         exc_warp_d = head_s[8:4];
      end else begin
         exc_warp_d = exc_warp_q;
      end
   end

   // Control and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= {AW{1'b0}};
         rd_ptr_q    <= {AW{1'b0}};
         count_q     <= {CW{1'b0}};
         retired_q   <= 16'h0000;
         exc_valid_q <= 1'b0;
         exc_warp_q  <= 5'd0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         retired_q   <= retired_d;
         exc_valid_q <= exc_valid_d;
         exc_warp_q  <= exc_warp_d;
      end
   end

   // Result storage; entries are cleared on reset so nothing stale is replayed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {EW{1'b0}};
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= entry_s;
      end
   end

   // rf_* are zeroed outside a WRITE head so reset and idle present clean values
   always_comb begin
      wb_ready  = wb_ready_s;
      rf_valid  = head_write_s;
      count     = count_q;
      retired   = retired_q;
      exc_valid = exc_valid_q;
      exc_warp  = exc_warp_q;
      if (head_write_s) begin
         rf_addr  = head_s[8:0];
         rf_wdata = head_s[61:30];
         rf_we    = head_s[29:26];
         rf_flags = head_s[25:10];
      end else begin
         rf_addr  = 9'h000;
         rf_wdata = 32'h0000_0000;
         rf_we    = 4'h0;
         rf_flags = 16'h0000;
      end
   end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Randomised and directed bench for alu_wb_stage, checked against a queue-level
// model of the result buffer by a negedge monitor.
module tb_alu_wb_stage;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        done = 1'b0;
   logic        wb_ready;
   logic [31:0] alu_out = 32'h0;
   logic [3:0]  write_en = 4'h0;
   logic [3:0]  Z = 4'h0, N = 4'h0, C = 4'h0, V = 4'h0;
   logic        illegal_opcode = 1'b0;
   logic [4:0]  warp_id_i = 5'd0;
   logic [3:0]  dst_reg = 4'd0;
   logic        flush = 1'b0;
   logic        rf_valid;
   logic        rf_ready = 1'b0;
   logic [8:0]  rf_addr;
   logic [31:0] rf_wdata;
   logic [3:0]  rf_we;
   logic [15:0] rf_flags;
   logic        exc_valid;
   logic [4:0]  exc_warp;
   logic [$clog2(DEPTH):0] count;
   logic [15:0] retired;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  we;
      logic [15:0] fl;
      logic        ill;
      logic [4:0]  w;
      logic [3:0]  r;
   } ent_t;

   ent_t        buf_q[$];
   logic        exc_q[$];
   logic [15:0] m_ret = 16'h0;
   logic [4:0]  m_exc_warp = 5'd0;

   alu_wb_stage #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .done(done), .wb_ready(wb_ready),
      .alu_out(alu_out), .write_en(write_en), .Z(Z), .N(N), .C(C), .V(V),
      .illegal_opcode(illegal_opcode), .warp_id_i(warp_id_i), .dst_reg(dst_reg),
      .flush(flush), .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr),
      .rf_wdata(rf_wdata), .rf_we(rf_we), .rf_flags(rf_flags),
      .exc_valid(exc_valid), .exc_warp(exc_warp), .count(count), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic d, input logic [31:0] a, input logic [3:0] we,
                        input logic ill, input logic [4:0] w, input logic [3:0] r);
      done = d; alu_out = a; write_en = we; illegal_opcode = ill;
      warp_id_i = w; dst_reg = r;
      {V, C, N, Z} = 16'($urandom);
   endtask

   // Reference model: the buffer as an ordered queue, updated once per clock
   initial begin
      ent_t e;
      int   sz;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            buf_q.delete(); exc_q.delete(); m_ret = 16'h0; m_exc_warp = 5'd0;
         end else if (flush) begin
            buf_q.delete();
         end else begin
            sz = buf_q.size();
            if (sz > 0) begin
               if (buf_q[0].ill) begin
                  exc_q.push_back(1'b1);
                  m_exc_warp = buf_q[0].w;
                  void'(buf_q.pop_front());
               end else if (buf_q[0].we == 4'h0) begin
                  void'(buf_q.pop_front());
               end else if (rf_ready) begin
                  void'(buf_q.pop_front());
                  if (m_ret != 16'hFFFF) m_ret = m_ret + 16'h1;
               end
            end
            if (done && sz < DEPTH) begin
               e.d = alu_out; e.we = write_en; e.fl = {V, C, N, Z};
               e.ill = illegal_opcode; e.w = warp_id_i; e.r = dst_reg;
               buf_q.push_back(e);
            end
         end
      end
   end

   // Monitor: compares what the DUT presents against the model every cycle
   initial begin
      logic exp_v;
      forever begin
         @(negedge clk);
         exp_v = 1'b0;
         if (buf_q.size() > 0) exp_v = !buf_q[0].ill && (buf_q[0].we != 4'h0);
         chk("rf_valid", rf_valid, exp_v);
         if (exp_v && rf_valid)
            chk("rf_fields", {rf_addr, rf_wdata, rf_we, rf_flags},
                {buf_q[0].w, buf_q[0].r, buf_q[0].d, buf_q[0].we, buf_q[0].fl});
         chk("count", count, buf_q.size());
         chk("wb_ready", wb_ready, (buf_q.size() < DEPTH));
         chk("retired", retired, m_ret);
         chk("exc_warp", exc_warp, m_exc_warp);
         if (exc_q.size() > 0) begin
            void'(exc_q.pop_front());
            chk("exc_valid", exc_valid, 64'd1);
         end else begin
            chk("exc_valid", exc_valid, 64'd0);
         end
      end
   end

   initial begin
      #1 rst = 1'b0;
      repeat (3) step();
      chk("rst_outputs", {rf_valid, rf_we, rf_addr, rf_wdata, rf_flags, exc_valid, exc_warp},
          64'd0);
      chk("rst_count", {wb_ready, count, retired}, {1'b1, 2'd0, 16'd0});
      rst = 1'b1;
      step();

      // single write
      rf_ready = 1'b1;
      drive(1'b1, 32'h04030201, 4'hF, 1'b0, 5'd7, 4'd3);
      step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      chk("single_valid", rf_valid, 64'd1);
      chk("single_addr", rf_addr, 64'h073);
      chk("single_data", {rf_wdata, rf_we}, {32'h04030201, 4'hF});
      step();
      chk("single_retired", retired, 64'd1);

      // backpressure: third push refused while full
      rf_ready = 1'b0;
      drive(1'b1, 32'h11111111, 4'hF, 1'b0, 5'd1, 4'd1); step();
      drive(1'b1, 32'h22222222, 4'h3, 1'b0, 5'd2, 4'd2); step();
      drive(1'b1, 32'h33333333, 4'hF, 1'b0, 5'd3, 4'd3); step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      chk("bp_full", {count, wb_ready}, {2'd2, 1'b0});
      for (int i = 0; i < 8; i++) begin
         chk("bp_stable", {rf_valid, rf_addr, rf_wdata, rf_we}, {1'b1, 9'h011, 32'h11111111, 4'hF});
         step();
      end
      rf_ready = 1'b1;
      chk("bp_pop_cycle_ready", wb_ready, 64'd0);
      step();
      chk("bp_ready_back", wb_ready, 64'd1);
      chk("bp_second", {rf_addr, rf_wdata, rf_we}, {9'h022, 32'h22222222, 4'h3});
      step();
      chk("bp_drained", {count, retired}, {2'd0, 16'd3});

      // masked lanes, then an all-lanes-off drop
      drive(1'b1, 32'hA0B0C0D0, 4'b1010, 1'b0, 5'd2, 4'd5); step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      chk("mask_data", {rf_we, rf_wdata}, {4'b1010, 32'hA0B0C0D0});
      step();
      drive(1'b1, 32'hDEADBEEF, 4'b0000, 1'b0, 5'd4, 4'd6); step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      chk("drop_no_valid", rf_valid, 64'd0);
      step();
      chk("drop_retired", {retired, count}, {16'd4, 2'd0});

      // illegal op
      drive(1'b1, 32'h12345678, 4'hF, 1'b1, 5'd7, 4'd1); step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      chk("exc_no_write", {rf_valid, exc_valid}, 64'd0);
      step();
      chk("exc_pulse", {exc_valid, exc_warp, count}, {1'b1, 5'd7, 2'd0});
      step();
      chk("exc_hold", {exc_valid, exc_warp}, {1'b0, 5'd7});

      // flush with full buffer and with one entry plus concurrent push
      rf_ready = 1'b0;
      drive(1'b1, 32'hCAFE0001, 4'hF, 1'b0, 5'd5, 4'd1); step();
      drive(1'b1, 32'hCAFE0002, 4'hF, 1'b0, 5'd5, 4'd2); step();
      chk("flush_pre", count, 64'd2);
      flush = 1'b1;
      drive(1'b1, 32'hCAFE0003, 4'hF, 1'b0, 5'd5, 4'd3); step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      chk("flush_full", {count, rf_valid, wb_ready}, {2'd0, 1'b0, 1'b1});
      drive(1'b1, 32'hCAFE0004, 4'hF, 1'b0, 5'd5, 4'd4); step();
      flush = 1'b1;
      drive(1'b1, 32'hCAFE0005, 4'hF, 1'b0, 5'd5, 4'd5); step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      chk("flush_push_lost", {count, rf_valid}, {2'd0, 1'b0});

      // asynchronous reset in the middle of a stall
      drive(1'b1, 32'hBEEF0001, 4'hF, 1'b0, 5'd3, 4'd9); step();
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      chk("stall_valid", rf_valid, 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_outputs", {rf_valid, rf_we, rf_addr, rf_wdata, rf_flags, exc_valid, exc_warp},
          64'd0);
      chk("async_rst_count", {wb_ready, count, retired}, {1'b1, 2'd0, 16'd0});
      step();
      rst = 1'b1;
      step();
      chk("rst_not_replayed", {rf_valid, count}, {1'b0, 2'd0});

      // randomised traffic
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 1) == 1), $urandom,
               ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom),
               ($urandom_range(0, 7) == 0), 5'($urandom), 4'($urandom));
         rf_ready = ($urandom_range(0, 9) < 6);
         flush = ($urandom_range(0, 39) == 0);
         step();
      end
      drive(1'b0, 32'h0, 4'h0, 1'b0, 5'd0, 4'd0);
      flush = 1'b0;
      rf_ready = 1'b1;
      repeat (10) step();
      chk("final_empty", count, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning result-buffer entries (power of two, 2..8).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- done  in  1  ALU result valid.
- wb_ready  out  1  stage can accept a result this cycle.
- alu_out  in  32  four 8-bit lane results, lane i = bits [8i+7:8i].
- write_en  in  4  per-lane write enable.
- Z, N, C, V  in  4 each  per-lane flags.
- illegal_opcode  in  1  result carries an illegal-op exception.
- warp_id_i  in  5  issuing warp.
- dst_reg  in  4  destination register index.
- flush  in  1  synchronous buffer clear.
- rf_valid  out  1  register-file write request.
- rf_ready  in  1  register file accepts the write.
- rf_addr  out  9  {warp_id, dst_reg}.
- rf_wdata  out  32  write data.
- rf_we  out  4  lane byte enables.
- rf_flags  out  16  {V,C,N,Z}, valid with rf_valid.
- exc_valid  out  1  one-cycle illegal-op pulse.
- exc_warp  out  5  warp of the exception.
- count  out  log2(DEPTH)+1  buffer occupancy.
- retired  out  16  completed RF writes, saturating.

Function
REQ-003 SHALL drive wb_ready = (count < DEPTH), decoded from registered count only, never from rf_ready or done.
REQ-004 SHALL push {alu_out, write_en, flags, illegal_opcode, warp_id_i, dst_reg} into the FIFO tail on every cycle where done && wb_ready.
REQ-005 SHALL ignore done while wb_ready=0; the upstream ALU holds its result until wb_ready.
REQ-006 SHALL classify the head entry when count>0:
- WRITE: illegal=0 and write_en!=0.
- EXC: illegal=1.
- DROP: illegal=0 and write_en=0.
REQ-007 WRITE: SHALL assert rf_valid with rf_addr, rf_wdata, rf_we=write_en and rf_flags from the head; pop when rf_valid && rf_ready.
REQ-008 WRITE: SHALL hold rf_valid and all rf_* outputs stable while rf_ready=0.
REQ-009 EXC: SHALL pop in one cycle with rf_valid=0, pulse exc_valid the following cycle, and hold exc_warp until the next exception.
REQ-010 DROP: SHALL pop in one cycle with rf_valid=0 and no exception.
REQ-011 Latency: a result pushed in cycle N SHALL be presentable on rf_* no earlier than cycle N+1; on an empty buffer it SHALL be presented exactly at N+1.
REQ-012 Ordering SHALL be strict FIFO; a stalled WRITE head blocks all younger entries.
REQ-013 Simultaneous push and pop SHALL leave count unchanged; the pointers wrap modulo DEPTH.
REQ-014 Full with a pop: wb_ready SHALL stay 0 that cycle and rise the next cycle.
REQ-015 flush SHALL have priority over push and pop:
- next cycle: count=0, pointers=0, rf_valid=0.
- no exc_valid is generated for flushed entries.
- a push coinciding with flush SHALL be discarded.
REQ-016 retired SHALL increment on each WRITE pop and saturate at 16'hFFFF.
REQ-017 rf_wdata, rf_we and rf_flags SHALL be don't-care when rf_valid=0; the bench checks them only under rf_valid.

Reset
REQ-018 While rst=0 the stage SHALL asynchronously hold:
- count=0, pointers=0.
- rf_valid=0, rf_we=0, rf_addr=0, rf_wdata=0, rf_flags=0.
- exc_valid=0, exc_warp=0, retired=0, wb_ready=1.
REQ-019 Deassertion of rst mid-transfer SHALL start from that state; buffered entries are lost, not replayed.

Verification
REQ-020 Single write:
- stimulus: done with alu_out=32'h04030201, write_en=4'hF, warp 7, dst_reg 3, rf_ready=1.
- response: next cycle rf_valid=1, rf_addr=9'h073, rf_wdata=32'h04030201, rf_we=4'hF; retired=1.
REQ-021 Backpressure:
- stimulus: rf_ready=0; push three results on consecutive cycles.
- response: count=2, wb_ready=0, third push ignored; rf outputs stable for 8 cycles.
- then: rf_ready=1 drains in order, and wb_ready returns 1 one cycle after the first pop.
REQ-022 Masked lanes:
- stimulus: write_en=4'b1010, alu_out=32'hA0B0C0D0.
- response: rf_we=4'b1010, rf_wdata=32'hA0B0C0D0; write_en=4'b0000 produces no rf_valid and retired unchanged.
REQ-023 Illegal op:
- stimulus: illegal_opcode=1, warp 7.
- response: rf_valid stays 0, exc_valid one-cycle pulse, exc_warp=7, count returns to 0.
REQ-024 Flush and reset:
- stimulus: flush with count=2 and a concurrent push.
- response: next cycle count=0, rf_valid=0.
- stimulus: rst=0 mid-stall.
- response: all outputs at REQ-018 values immediately, without a clock edge.
